// File: rtl/rand_lanes.sv
// Multi-lane xorshift32 PRNG with a reseed/warm-up FSM and per-lane
// density-thresholded cell bits for board initialisation.
module rand_lanes #(
  parameter int unsigned LANES        = 8,
  parameter int unsigned WARMUP       = 16,
  parameter logic [31:0] SEED_DEFAULT = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  input  logic                  en,
  input  logic [7:0]            density,
  output logic [LANES*32-1:0]   rand_out,
  output logic [LANES-1:0]      cell_bits,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned CW     = (WARMUP == 0) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CW-1:0] LAST = CW'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_lane [LANES];
  logic          w_step;

  // Per-lane seed; zero is an absorbing state for xorshift so it is replaced.
  function automatic logic [31:0] lane_seed(input logic [31:0] s, input int unsigned i);
    logic [31:0] v;
    v = s + 32'(i) * GOLDEN;
    return (v == 32'd0) ? 32'hDEADBEEF : v;
  endfunction

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (seed_load) begin
      w_next = (WARMUP == 0) ? RUN : WARM;
    end else begin
      case (r_state)
        WARM:    if (r_cnt == LAST) w_next = RUN;
        default: w_next = r_state;
      endcase
    end
  end

  // Seed load wins over both warm-up stepping and en.
  always_comb begin
    valid  = 1'b0;
    busy   = 1'b0;
    w_step = 1'b0;
    case (r_state)
      WARM: begin
        busy   = 1'b1;
        w_step = ~seed_load;
      end
      RUN: begin
        valid  = 1'b1;
        w_step = en & ~seed_load;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || seed_load)     r_cnt <= '0;
    else if (r_state == WARM) r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (rst)            r_lane[i] <= lane_seed(SEED_DEFAULT, i);
      else if (seed_load) r_lane[i] <= lane_seed(seed, i);
      else if (w_step)    r_lane[i] <= xs_step(r_lane[i]);
    end
  end

  always_comb begin
    rand_out  = '0;
    cell_bits = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      rand_out[32*i +: 32] = r_lane[i];
      cell_bits[i]         = valid & (r_lane[i][31:24] < density);
    end
  end

endmodule

// File: tb/tb_rand_lanes.sv
// Self-checking bench for rand_lanes: randomized stimulus against a
// behavioural model tracking lane values and remaining warm-up steps.
module tb_rand_lanes;

  localparam int unsigned L = 8;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, seed_load, seed_load0, en, en0;
  logic [31:0] seed;
  logic [7:0]  density;
  logic [L*32-1:0] rand_out;
  logic [L-1:0]    cell_bits;
  logic            valid, busy;
  logic [63:0]     rand_out0;
  logic [1:0]      cell_bits0;
  logic            valid0, busy0;

  int n_tests = 0;
  int n_fail  = 0;

  rand_lanes #(.LANES(L), .WARMUP(W), .SEED_DEFAULT(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .en(en),
    .density(density), .rand_out(rand_out), .cell_bits(cell_bits),
    .valid(valid), .busy(busy)
  );

  rand_lanes #(.LANES(2), .WARMUP(0), .SEED_DEFAULT(32'hDEADBEEF)) dut0 (
    .clk(clk), .rst(rst), .seed_load(seed_load0), .seed(seed), .en(en0),
    .density(density), .rand_out(rand_out0), .cell_bits(cell_bits0),
    .valid(valid0), .busy(busy0)
  );

  // Model: lane values, whether a seed was ever loaded, steps left to discard.
  logic [31:0] m_lane [L];
  bit          m_idle;
  int          m_rem;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] seed_of(input logic [31:0] s, input int i);
    logic [31:0] v;
    v = s + 32'(i) * 32'h9E3779B9;
    return (v == 0) ? 32'hDEADBEEF : v;
  endfunction

  function automatic logic [L*32-1:0] exp_rand();
    logic [L*32-1:0] r;
    for (int i = 0; i < int'(L); i++) r[32*i +: 32] = m_lane[i];
    return r;
  endfunction

  function automatic bit exp_valid();
    return !m_idle && m_rem == 0;
  endfunction

  function automatic bit exp_busy();
    return !m_idle && m_rem > 0;
  endfunction

  function automatic logic [L-1:0] exp_cells();
    logic [L-1:0] c;
    logic [7:0]   top;
    c = '0;
    for (int i = 0; i < int'(L); i++) begin
      top = m_lane[i][31:24];
      if (!exp_valid())          c[i] = 1'b0;
      else if (density == 8'd0)  c[i] = 1'b0;
      else if (density == 8'd255) c[i] = (top != 8'hFF);
      else if (density == 8'd128) c[i] = ~m_lane[i][31];
      else                       c[i] = (top < density);
    end
    return c;
  endfunction

  task automatic model_clock();
    if (rst) begin
      for (int i = 0; i < int'(L); i++) m_lane[i] = seed_of(32'hDEADBEEF, i);
      m_idle = 1;
      m_rem  = 0;
    end else if (seed_load) begin
      for (int i = 0; i < int'(L); i++) m_lane[i] = seed_of(seed, i);
      m_idle = 0;
      m_rem  = W;
    end else if (!m_idle && (m_rem > 0 || en)) begin
      for (int i = 0; i < int'(L); i++) m_lane[i] = xs(m_lane[i]);
      if (m_rem > 0) m_rem--;
    end
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; cycle(); cycle(); rst = 0;
    n_tests++;
    if (rand_out !== exp_rand()) begin
      n_fail++; $display("FAIL reset_lanes got %h exp %h", rand_out, exp_rand());
    end
    n_tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || cell_bits !== '0) begin
      n_fail++; $display("FAIL reset_flags got v=%b b=%b c=%b exp 0 0 0", valid, busy, cell_bits);
    end
    n_tests++;
    if (rand_out0 !== {seed_of(32'hDEADBEEF, 1), seed_of(32'hDEADBEEF, 0)} || valid0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut0 got %h v=%b", rand_out0, valid0);
    end
  endtask

  task automatic test_warmup0();
    seed = 32'd1; seed_load0 = 1; cycle(); seed_load0 = 0;
    n_tests++;
    if (rand_out0 !== {32'h9E3779BA, 32'h00000001} || valid0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL w0_load got %h v=%b b=%b exp 9e3779ba00000001 1 0", rand_out0, valid0, busy0);
    end
    en0 = 1; cycle();
    n_tests++;
    if (rand_out0[31:0] !== 32'd270369) begin
      n_fail++; $display("FAIL w0_step1 got %0d exp 270369", rand_out0[31:0]);
    end
    cycle(); en0 = 0;
    n_tests++;
    if (rand_out0[31:0] !== 32'd67634689) begin
      n_fail++; $display("FAIL w0_step2 got %0d exp 67634689", rand_out0[31:0]);
    end
    cycle();
    n_tests++;
    if (rand_out0[31:0] !== 32'd67634689) begin
      n_fail++; $display("FAIL w0_hold got %0d exp 67634689", rand_out0[31:0]);
    end
  endtask

  task automatic test_warmup();
    logic [31:0] x;
    seed = 32'd1; en = 0; seed_load = 1; cycle(); seed_load = 0;
    for (int k = 0; k < int'(W); k++) begin
      n_tests++;
      if (busy !== 1'b1 || valid !== 1'b0 || rand_out !== exp_rand()) begin
        n_fail++; $display("FAIL warm_cycle%0d got b=%b v=%b lane0=%h exp 1 0 %h", k, busy, valid, rand_out[31:0], m_lane[0]);
      end
      cycle();
    end
    x = 32'd1;
    for (int k = 0; k < 16; k++) x = xs(x);
    n_tests++;
    if (valid !== 1'b1 || busy !== 1'b0 || rand_out[31:0] !== x) begin
      n_fail++; $display("FAIL warm_done got v=%b b=%b lane0=%h exp 1 0 %h", valid, busy, rand_out[31:0], x);
    end
  endtask

  task automatic test_seed_zero();
    seed = 32'd0; seed_load = 1; cycle(); seed_load = 0;
    n_tests++;
    if (rand_out[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL seed0_lane0 got %h exp deadbeef", rand_out[31:0]);
    end
    seed = 32'h61C88647; seed_load = 1; cycle(); seed_load = 0;
    n_tests++;
    if (rand_out[63:32] !== 32'hDEADBEEF || rand_out[31:0] !== 32'h61C88647) begin
      n_fail++; $display("FAIL seedneg_lane1 got %h exp deadbeef61c88647", rand_out[63:0]);
    end
  endtask

  task automatic test_density();
    for (int k = 0; k < int'(W); k++) cycle();
    for (int k = 0; k < 60; k++) begin
      case (k % 4)
        0: density = 8'd0;
        1: density = 8'd255;
        2: density = 8'd128;
        default: density = 8'($urandom);
      endcase
      en = 1'($urandom);
      cycle();
      n_tests++;
      if (cell_bits !== exp_cells()) begin
        n_fail++; $display("FAIL density%0d got %b exp %b", density, cell_bits, exp_cells());
      end
    end
  endtask

  task automatic test_restart();
    seed = $urandom; seed_load = 1; cycle(); seed_load = 0;
    en = 1;
    for (int k = 0; k < 5; k++) cycle();
    seed = $urandom; seed_load = 1; cycle(); seed_load = 0;
    for (int k = 0; k < int'(W); k++) begin
      n_tests++;
      if (busy !== 1'b1 || valid !== 1'b0 || rand_out !== exp_rand()) begin
        n_fail++; $display("FAIL restart_cycle%0d got b=%b v=%b lane0=%h exp 1 0 %h", k, busy, valid, rand_out[31:0], m_lane[0]);
      end
      cycle();
    end
    n_tests++;
    if (valid !== 1'b1 || rand_out !== exp_rand()) begin
      n_fail++; $display("FAIL restart_done got v=%b lane0=%h exp 1 %h", valid, rand_out[31:0], m_lane[0]);
    end
    cycle(); cycle();
    density = 8'd255;
    rst = 1; seed_load = 1; cycle(); rst = 0; seed_load = 0;
    n_tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || cell_bits !== '0 || rand_out !== exp_rand()) begin
      n_fail++; $display("FAIL rst_in_run got v=%b b=%b c=%b lane0=%h exp 0 0 0 deadbeef", valid, busy, cell_bits, rand_out[31:0]);
    end
    cycle(); cycle();
    n_tests++;
    if (rand_out !== exp_rand() || valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold got lane0=%h v=%b exp %h 0", rand_out[31:0], valid, m_lane[0]);
    end
    en = 0;
  endtask

  task automatic test_random_run();
    seed = $urandom; seed_load = 1; cycle(); seed_load = 0;
    for (int k = 0; k < int'(W); k++) cycle();
    for (int k = 0; k < 1000; k++) begin
      en      = 1'($urandom);
      density = 8'($urandom);
      cycle();
      n_tests++;
      if (rand_out !== exp_rand() || valid !== 1'b1 || cell_bits !== exp_cells()) begin
        n_fail++; $display("FAIL run%0d got lane0=%h v=%b c=%b exp %h 1 %b", k, rand_out[31:0], valid, cell_bits, m_lane[0], exp_cells());
      end
      for (int i = 0; i < int'(L); i++) begin
        n_tests++;
        if (rand_out[32*i +: 32] == 32'd0) begin
          n_fail++; $display("FAIL run%0d_nonzero lane%0d got 0 exp nonzero", k, i);
        end
      end
    end
  endtask

  initial begin
    rst = 1; seed_load = 0; seed_load0 = 0; en = 0; en0 = 0;
    seed = 0; density = 8'd255;
    m_idle = 1; m_rem = 0;
    for (int i = 0; i < int'(L); i++) m_lane[i] = 0;
    #1;
    test_reset();
    test_warmup0();
    test_warmup();
    test_seed_zero();
    test_density();
    test_restart();
    test_random_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
